// File: rtl/apb2wb_bridge_v2.sv
// APB4 slave to Wishbone classic master bridge: one APB transfer becomes one WB cycle.
// Optional WB wait timeout and privileged-access filter; all bus outputs are registered.
module apb2wb_bridge_v2 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int PROT_CHECK     = 0
) (
  input  logic                    PCLK_i,
  input  logic                    PRESETn_i,
  input  logic [ADDR_WIDTH-1:0]   PADDR_i,
  input  logic [2:0]              PPROT_i,
  input  logic                    PSEL_i,
  input  logic                    PENABLE_i,
  input  logic                    PWRITE_i,
  input  logic [DATA_WIDTH-1:0]   PWDATA_i,
  input  logic [DATA_WIDTH/8-1:0] PSTRB_i,
  output logic                    PREADY_o,
  output logic [DATA_WIDTH-1:0]   PRDATA_o,
  output logic                    PSLVERR_o,
  output logic                    wb_clk_o,
  output logic                    wb_rst_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [STRB_W-1:0]     sel_q, sel_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic setup_seen;
  logic prot_ok;
  logic timeout_hit;
  logic unused_prot;

  assign setup_seen  = PSEL_i && !PENABLE_i;
  assign prot_ok     = (PROT_CHECK == 0) || PPROT_i[0];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);
  assign unused_prot = ^PPROT_i[2:1];

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (setup_seen) begin
          if (!prot_ok) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            adr_d   = PADDR_i;
            dat_d   = PWDATA_i;
            we_d    = PWRITE_i;
            sel_d   = PWRITE_i ? PSTRB_i : {STRB_W{1'b1}};
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        // Error outranks ack, and either outranks a timeout landing on the same cycle.
        if (wb_err_i || wb_ack_i || timeout_hit) begin
          state_d   = S_RESP;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          cnt_d     = '0;
          pready_d  = 1'b1;
          pslverr_d = wb_err_i || !wb_ack_i;
          prdata_d  = (!wb_err_i && wb_ack_i && !we_q) ? wb_dat_i : '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign wb_clk_o  = PCLK_i;
  assign wb_rst_o  = ~PRESETn_i;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign PREADY_o  = pready_q;
  assign PSLVERR_o = pslverr_q;
  assign PRDATA_o  = prdata_q;

endmodule

// File: tb/tb_apb2wb_bridge_v2.sv
// Scoreboarded bench for apb2wb_bridge_v2: a 32-bit instance (timeout 4, privilege filter on)
// and a 64-bit instance (no timeout, filter off) share the APB/WB stimulus, gated by use_b.
module tb_apb2wb_bridge_v2;

  localparam int NONE = 0, ACK = 1, ERR = 2, BOTH = 3;
  localparam int O_NONE = 0, O_DROP = 1, O_RESETUP = 2, O_EARLY = 3, O_ABORT = 4;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          wbc;
    logic [31:0] adr;
    logic [63:0] dat;
    logic [7:0]  sel;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        use_b = 1'b0;
  logic [31:0] paddr = '0;
  logic [2:0]  pprot = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [63:0] pwdata = '0;
  logic [7:0]  pstrb = '0;
  logic [63:0] wb_rdat = '0;
  logic        wb_ack = 1'b0, wb_err = 1'b0;

  logic        a_pready, a_pslverr, a_wclk, a_wrst, a_cyc, a_stb, a_we;
  logic [31:0] a_prdata, a_adr, a_dat;
  logic [3:0]  a_sel;
  logic        b_pready, b_pslverr, b_wclk, b_wrst, b_cyc, b_stb, b_we;
  logic [63:0] b_prdata, b_dat;
  logic [31:0] b_adr;
  logic [7:0]  b_sel;

  logic        m_pready, m_pslverr, m_cyc, m_stb, m_we, m_wrst;
  logic [63:0] m_prdata, m_dat;
  logic [31:0] m_adr;
  logic [7:0]  m_sel;

  exp_t exp_q[$];
  int   n_checks = 0, n_pass = 0;
  int   cyc_cnt = 0, setup_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  apb2wb_bridge_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .PROT_CHECK(1)) u_a (
    .PCLK_i(clk), .PRESETn_i(rst_n), .PADDR_i(paddr), .PPROT_i(pprot),
    .PSEL_i(psel & ~use_b), .PENABLE_i(penable), .PWRITE_i(pwrite),
    .PWDATA_i(pwdata[31:0]), .PSTRB_i(pstrb[3:0]),
    .PREADY_o(a_pready), .PRDATA_o(a_prdata), .PSLVERR_o(a_pslverr),
    .wb_clk_o(a_wclk), .wb_rst_o(a_wrst), .wb_cyc_o(a_cyc), .wb_stb_o(a_stb),
    .wb_we_o(a_we), .wb_adr_o(a_adr), .wb_dat_o(a_dat), .wb_sel_o(a_sel),
    .wb_dat_i(wb_rdat[31:0]), .wb_ack_i(wb_ack), .wb_err_i(wb_err));

  apb2wb_bridge_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(0), .PROT_CHECK(0)) u_b (
    .PCLK_i(clk), .PRESETn_i(rst_n), .PADDR_i(paddr), .PPROT_i(pprot),
    .PSEL_i(psel & use_b), .PENABLE_i(penable), .PWRITE_i(pwrite),
    .PWDATA_i(pwdata), .PSTRB_i(pstrb),
    .PREADY_o(b_pready), .PRDATA_o(b_prdata), .PSLVERR_o(b_pslverr),
    .wb_clk_o(b_wclk), .wb_rst_o(b_wrst), .wb_cyc_o(b_cyc), .wb_stb_o(b_stb),
    .wb_we_o(b_we), .wb_adr_o(b_adr), .wb_dat_o(b_dat), .wb_sel_o(b_sel),
    .wb_dat_i(wb_rdat), .wb_ack_i(wb_ack), .wb_err_i(wb_err));

  assign m_pready  = use_b ? b_pready  : a_pready;
  assign m_pslverr = use_b ? b_pslverr : a_pslverr;
  assign m_prdata  = use_b ? b_prdata  : {32'h0, a_prdata};
  assign m_cyc     = use_b ? b_cyc     : a_cyc;
  assign m_stb     = use_b ? b_stb     : a_stb;
  assign m_we      = use_b ? b_we      : a_we;
  assign m_adr     = use_b ? b_adr     : a_adr;
  assign m_dat     = use_b ? b_dat     : {32'h0, a_dat};
  assign m_sel     = use_b ? b_sel     : {4'h0, a_sel};
  assign m_wrst    = use_b ? b_wrst    : a_wrst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  // Monitor: tracks the WB cycle as it runs and scores each PREADY_o pulse against the queue.
  int          wbc = 0;
  logic        unstable = 1'b0;
  logic        snap_stb, snap_we;
  logic [31:0] snap_adr;
  logic [63:0] snap_dat;
  logic [7:0]  snap_sel;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      wbc = 0;
      unstable = 1'b0;
    end else begin
      if (m_cyc) begin
        if (wbc == 0) begin
          snap_stb = m_stb; snap_we = m_we; snap_adr = m_adr; snap_dat = m_dat; snap_sel = m_sel;
        end else if ({m_stb, m_we, m_adr, m_dat, m_sel} !== {snap_stb, snap_we, snap_adr, snap_dat, snap_sel}) begin
          unstable = 1'b1;
        end
        wbc++;
      end
      if (m_pready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pready: got PREADY_o=1, required no response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("prdata", m_prdata, e.rdata);
          chk("pslverr", 64'(m_pslverr), 64'(e.err));
          chk("latency", 64'(cyc_cnt - setup_cyc), 64'(e.lat));
          chk("wb_cycles", 64'(wbc), 64'(e.wbc));
          if (e.wbc > 0) begin
            chk("wb_stb", 64'(snap_stb), 64'd1);
            chk("wb_adr", 64'(snap_adr), 64'(e.adr));
            chk("wb_dat", snap_dat, e.dat);
            chk("wb_sel", 64'(snap_sel), 64'(e.sel));
            chk("wb_we", 64'(snap_we), 64'(e.we));
            chk("wb_stable", 64'(unstable), 64'd0);
          end
        end
        wbc = 0;
        unstable = 1'b0;
      end
    end
  end

  task automatic drive_slave(input int kind, input int i, input int wait_n);
    wb_ack = ((kind == ACK) || (kind == BOTH)) && (i == wait_n);
    wb_err = ((kind == ERR) || (kind == BOTH)) && (i == wait_n);
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] strb, input logic [2:0] prot, input int kind,
                      input int wait_n, input logic [63:0] rdata, input int opt,
                      input logic [63:0] x_rdata, input logic x_err, input int x_lat,
                      input int x_wbc, input logic [63:0] x_dat, input logic [7:0] x_sel);
    exp_t e;
    int   i;
    bit   done;
    e.rdata = x_rdata; e.err = x_err; e.lat = x_lat; e.wbc = x_wbc;
    e.adr = addr; e.dat = x_dat; e.sel = x_sel; e.we = wr;
    if (opt != O_ABORT) exp_q.push_back(e);
    setup_cyc = cyc_cnt;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    pstrb = strb; pprot = prot; wb_rdat = rdata;
    if (opt == O_EARLY) begin wb_ack = 1'b1; wb_err = 1'b1; end
    @(negedge clk);
    penable = 1'b1;
    wb_ack = 1'b0; wb_err = 1'b0;
    if (opt == O_DROP) begin psel = 1'b0; penable = 1'b0; end
    if (opt == O_RESETUP) begin
      penable = 1'b0; paddr = 32'h999; pwrite = 1'b1; pwdata = 64'h5555; pstrb = 8'hFF;
    end
    if (opt == O_ABORT) begin
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cyc_async", 64'(m_cyc), 64'd0);
      chk("rst_stb_async", 64'(m_stb), 64'd0);
      chk("rst_pready", 64'(m_pready), 64'd0);
      chk("wb_rst_o", 64'(m_wrst), 64'd1);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    i = 0;
    done = 0;
    while (!done && i < 60) begin
      if (m_pready) done = 1;
      else begin
        drive_slave(kind, i, wait_n);
        @(negedge clk);
        i++;
      end
    end
    wb_ack = 1'b0; wb_err = 1'b0;
    psel = 1'b0; penable = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL pready_wait: got no PREADY_o within 60 cycles, required a response (addr 0x%0h)", addr);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cyc", 64'(m_cyc), 64'd0);
    chk("rst_stb", 64'(m_stb), 64'd0);
    chk("rst_we", 64'(m_we), 64'd0);
    chk("rst_adr", 64'(m_adr), 64'd0);
    chk("rst_dat", m_dat, 64'd0);
    chk("rst_sel", 64'(m_sel), 64'd0);
    chk("rst_pready", 64'(m_pready), 64'd0);
    chk("rst_pslverr", 64'(m_pslverr), 64'd0);
    chk("rst_prdata", m_prdata, 64'd0);
    chk("rst_wb_rst", 64'(m_wrst), 64'd1);
    rst_n = 1'b1;

    // 32-bit instance, timeout 4, privilege filter on
    xfer(1, 32'h10, 64'hA5A5_1234, 8'h03, 3'b001, ACK, 0, 64'h0, O_NONE, 64'h0, 0, 2, 1, 64'hA5A5_1234, 8'h03);
    xfer(0, 32'h14, 64'h0, 8'h00, 3'b001, ACK, 3, 64'hDEAD_BEEF, O_NONE, 64'hDEAD_BEEF, 0, 5, 4, 64'h0, 8'h0F);
    xfer(0, 32'h20, 64'h0, 8'h00, 3'b001, ACK, 1, 64'h1234_5678, O_NONE, 64'h1234_5678, 0, 3, 2, 64'h0, 8'h0F);
    xfer(1, 32'h30, 64'h1111_2222, 8'h0F, 3'b001, NONE, 0, 64'h0, O_NONE, 64'h0, 1, 5, 4, 64'h1111_2222, 8'h0F);
    xfer(0, 32'h34, 64'h0, 8'h00, 3'b001, NONE, 0, 64'hCAFE_F00D, O_NONE, 64'h0, 1, 5, 4, 64'h0, 8'h0F);
    xfer(0, 32'h40, 64'h0, 8'h00, 3'b001, BOTH, 1, 64'h55AA_55AA, O_NONE, 64'h0, 1, 3, 2, 64'h0, 8'h0F);
    xfer(1, 32'h44, 64'h0000_BEEF, 8'h0C, 3'b001, ERR, 0, 64'h0, O_NONE, 64'h0, 1, 2, 1, 64'h0000_BEEF, 8'h0C);
    xfer(1, 32'h50, 64'h77, 8'h0F, 3'b000, ACK, 0, 64'h99, O_NONE, 64'h0, 1, 1, 0, 64'h0, 8'h00);
    xfer(0, 32'h54, 64'h0, 8'h00, 3'b010, ACK, 0, 64'h99, O_NONE, 64'h0, 1, 1, 0, 64'h0, 8'h00);
    xfer(0, 32'h58, 64'h0, 8'h00, 3'b101, ACK, 0, 64'hA1B2_C3D4, O_NONE, 64'hA1B2_C3D4, 0, 2, 1, 64'h0, 8'h0F);
    xfer(0, 32'h60, 64'h0, 8'h00, 3'b001, ACK, 2, 64'h0BAD_CAFE, O_EARLY, 64'h0BAD_CAFE, 0, 4, 3, 64'h0, 8'h0F);
    xfer(1, 32'h70, 64'h89AB_CDEF, 8'h05, 3'b001, ACK, 2, 64'h0, O_DROP, 64'h0, 0, 4, 3, 64'h89AB_CDEF, 8'h05);
    xfer(0, 32'h80, 64'h0, 8'h00, 3'b001, ACK, 1, 64'h2468_1357, O_RESETUP, 64'h2468_1357, 0, 3, 2, 64'h0, 8'h0F);
    xfer(1, 32'h90, 64'hFFFF_0000, 8'h0F, 3'b001, ACK, 0, 64'h0, O_ABORT, 64'h0, 0, 0, 0, 64'h0, 8'h00);
    xfer(0, 32'h94, 64'h0, 8'h00, 3'b001, ACK, 0, 64'h1357_9BDF, O_NONE, 64'h1357_9BDF, 0, 2, 1, 64'h0, 8'h0F);

    // stray ack/err while idle must not produce a response
    wb_ack = 1'b1; wb_err = 1'b1;
    repeat (3) @(negedge clk);
    wb_ack = 1'b0; wb_err = 1'b0;
    @(negedge clk);

    // 64-bit instance, no timeout, filter off
    use_b = 1'b1;
    @(negedge clk);
    xfer(1, 32'h100, 64'h0123_4567_89AB_CDEF, 8'hF0, 3'b000, ACK, 0, 64'h0, O_NONE, 64'h0, 0, 2, 1, 64'h0123_4567_89AB_CDEF, 8'hF0);
    xfer(0, 32'h108, 64'h0, 8'h00, 3'b000, ACK, 10, 64'hFEDC_BA98_7654_3210, O_NONE, 64'hFEDC_BA98_7654_3210, 0, 12, 11, 64'h0, 8'hFF);
    xfer(1, 32'h110, 64'h1111_2222_3333_4444, 8'hF0, 3'b001, ACK, 0, 64'h0, O_ABORT, 64'h0, 0, 0, 0, 64'h0, 8'h00);
    xfer(1, 32'h118, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 3'b001, ACK, 1, 64'h0, O_NONE, 64'h0, 0, 3, 2, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0);
    xfer(0, 32'h120, 64'h0, 8'h00, 3'b000, ERR, 4, 64'h5, O_NONE, 64'h0, 1, 6, 5, 64'h0, 8'hFF);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
